// File: rtl/gpio_axil_regs.sv
// AXI4-Lite slave register file for GPIO pin control (OUT/DIR/IEN/SCR/IN/ISTAT).
// Define GPIO_IRQ_EN to build the pin-change edge detector, ISTAT and irq.
module gpio_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned GPIO_WIDTH         = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [GPIO_WIDTH-1:0]             gpio_in,
  output logic [GPIO_WIDTH-1:0]             gpio_out,
  output logic [GPIO_WIDTH-1:0]             gpio_oe,
  output logic                              irq
);

  localparam int unsigned REG_W    = 32;
  localparam logic [REG_W-1:0] PIN_MASK = REG_W'((64'(1) << GPIO_WIDTH) - 64'(1));
  localparam logic [2:0] IDX_OUT   = 3'd0;
  localparam logic [2:0] IDX_DIR   = 3'd1;
  localparam logic [2:0] IDX_IEN   = 3'd2;
  localparam logic [2:0] IDX_SCR   = 3'd3;
  localparam logic [2:0] IDX_IN    = 3'd4;
  localparam logic [2:0] IDX_ISTAT = 3'd5;

  logic [REG_W-1:0]      out_q, dir_q, ien_q, scr_q, istat;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
  logic [REG_W-1:0]      in_val;
  logic                  aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
  logic [REG_W-1:0]      rd_hold_q, rdata_q;
  logic                  wr_en, rd_en;
  logic [2:0]            wr_idx, rd_idx;
  logic [REG_W-1:0]      rd_mux;
  logic                  unused_ok;

  // Byte-lane merge of write data into an existing register value
  function automatic logic [REG_W-1:0] merge(input logic [REG_W-1:0] old,
                                             input logic [REG_W-1:0] d,
                                             input logic [3:0]       s);
    logic [REG_W-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  assign wr_en  = S_AXI_AWVALID && S_AXI_WVALID && !aw_ready_q && !b_valid_q;
  assign rd_en  = S_AXI_ARVALID && !ar_ready_q && !r_valid_q;
  assign in_val = REG_W'(sync2_q);

  // Two-flop synchroniser for the asynchronous pin inputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // Write channel: accept when both AW and W are present and no response is pending
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      out_q      <= '0;
      dir_q      <= '0;
      ien_q      <= '0;
      scr_q      <= '0;
    end else begin
      aw_ready_q <= wr_en;
      if (aw_ready_q) begin
        b_valid_q <= 1'b1;
      end else if (b_valid_q && S_AXI_BREADY) begin
        b_valid_q <= 1'b0;
      end
      if (wr_en) begin
        case (wr_idx)
          IDX_OUT: out_q <= merge(out_q, S_AXI_WDATA, S_AXI_WSTRB) & PIN_MASK;
          IDX_DIR: dir_q <= merge(dir_q, S_AXI_WDATA, S_AXI_WSTRB) & PIN_MASK;
          IDX_IEN: ien_q <= merge(ien_q, S_AXI_WDATA, S_AXI_WSTRB) & PIN_MASK;
          IDX_SCR: scr_q <= merge(scr_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] sync_prev_q;
  logic [REG_W-1:0]      istat_q, istat_clr, pin_change;
  logic                  irq_q;

  assign istat_clr  = (wr_en && wr_idx == IDX_ISTAT) ?
                      merge('0, S_AXI_WDATA, S_AXI_WSTRB) : '0;
  assign pin_change = REG_W'(sync2_q ^ sync_prev_q);

  // Change detection; a new set wins over a simultaneous W1C clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync_prev_q <= '0;
      istat_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync_prev_q <= sync2_q;
      istat_q     <= ((istat_q & ~istat_clr) | (pin_change & ien_q)) & PIN_MASK;
      irq_q       <= |istat_q;
    end
  end

  assign istat = istat_q;
  assign irq   = irq_q;
`else
  assign istat = '0;
  assign irq   = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      IDX_OUT:   rd_mux = out_q;
      IDX_DIR:   rd_mux = dir_q;
      IDX_IEN:   rd_mux = ien_q;
      IDX_SCR:   rd_mux = scr_q;
      IDX_IN:    rd_mux = in_val;
      IDX_ISTAT: rd_mux = istat;
      default:   rd_mux = '0;
    endcase
  end

  // Read channel: snapshot taken at address accept, so a concurrent write returns the old value
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      rd_hold_q  <= '0;
      rdata_q    <= '0;
    end else begin
      ar_ready_q <= rd_en;
      if (rd_en) rd_hold_q <= rd_mux;
      if (ar_ready_q) begin
        r_valid_q <= 1'b1;
        rdata_q   <= rd_hold_q;
      end else if (r_valid_q && S_AXI_RREADY) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign gpio_out      = out_q[GPIO_WIDTH-1:0];
  assign gpio_oe       = dir_q[GPIO_WIDTH-1:0];

endmodule

// File: tb/tb_gpio_axil_regs.sv
// Directed self-checking bench for gpio_axil_regs (default GPIO_WIDTH=32).
// Exercises the GPIO_IRQ_EN path when that macro is defined for the build.
module tb_gpio_axil_regs;

  localparam int LIMIT = 20;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int passed = 0;
  int total  = 0;

  logic [31:0] rd;
  logic [1:0]  resp;

  gpio_axil_regs dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic timeout_fail(input string tag);
    total++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    int n;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge aclk); n++; end
    if (n >= LIMIT) timeout_fail("aw_wait");
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < LIMIT) begin @(negedge aclk); n++; end
    if (n >= LIMIT) timeout_fail("b_wait");
    r = bresp;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < LIMIT) begin @(negedge aclk); n++; end
    if (n >= LIMIT) timeout_fail("ar_wait");
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < LIMIT) begin @(negedge aclk); n++; end
    if (n >= LIMIT) timeout_fail("r_wait");
    d = rdata; r = rresp;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; gpio_in = '0;
    repeat (2) @(negedge aclk);
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready",  32'(wready),  32'h0);
    chk("rst_bvalid",  32'(bvalid),  32'h0);
    chk("rst_arready", 32'(arready), 32'h0);
    chk("rst_rvalid",  32'(rvalid),  32'h0);
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_irq",     32'(irq),     32'h0);
    chk("rst_gpio_out", gpio_out,    32'h0);
    aresetn = 1'b1;

    // 1: plain writes and readback of the four R/W registers
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), 32'(i + 1), 4'hF, resp);
      chk("t1_bresp", 32'(resp), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), rd, resp);
      chk("t1_rdata", rd, 32'(i + 1));
      chk("t1_rresp", 32'(resp), 32'h0);
    end
    chk("t1_gpio_out", gpio_out, 32'h1);
    chk("t1_gpio_oe",  gpio_oe,  32'h2);

    // 2: single byte-lane write
    axi_write(5'h00, 32'h0, 4'hF, resp);
    axi_write(5'h00, 32'hFFFF_FFFF, 4'b0010, resp);
    axi_read(5'h00, rd, resp);
    chk("t2_strb_rdata", rd, 32'h0000_FF00);
    chk("t2_gpio_out", gpio_out, 32'h0000_FF00);

    // 3: synchronised inputs, RO write ignored, unmapped addresses
    @(negedge aclk); gpio_in = 32'hA5A5_A5A5;
    repeat (3) @(negedge aclk);
    axi_read(5'h10, rd, resp);
    chk("t3_in", rd, 32'hA5A5_A5A5);
    axi_write(5'h10, 32'h1234_5678, 4'hF, resp);
    chk("t3_ro_bresp", 32'(resp), 32'h0);
    axi_read(5'h10, rd, resp);
    chk("t3_in_after_wr", rd, 32'hA5A5_A5A5);
    axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, resp);
    axi_read(5'h1C, rd, resp);
    chk("t3_unmapped_1c", rd, 32'h0);
    axi_read(5'h18, rd, resp);
    chk("t3_unmapped_18", rd, 32'h0);

    // 4: AW without W stalls; held BVALID blocks the next write
    @(negedge aclk);
    awaddr = 5'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_aw_only_ready", 32'(awready), 32'h0);
    end
    wvalid = 1'b1;
    @(negedge aclk);
    chk("t4_awready", 32'(awready), 32'h1);
    chk("t4_wready",  32'(wready),  32'h1);
    @(negedge aclk);
    awaddr = 5'h08; wdata = 32'h66;
    for (int i = 0; i < 4; i++) begin
      chk("t4_bvalid_held", 32'(bvalid), 32'h1);
      chk("t4_next_aw_blocked", 32'(awready), 32'h0);
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    chk("t4_bvalid_drop", 32'(bvalid), 32'h0);
    begin
      int n;
      n = 0;
      while (!awready && n < LIMIT) begin @(negedge aclk); n++; end
      if (n >= LIMIT) timeout_fail("t4_aw2_wait");
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t4_bvalid2", 32'(bvalid), 32'h1);
    @(negedge aclk);
    bready = 1'b0;
    axi_read(5'h0C, rd, resp);
    chk("t4_scr", rd, 32'h55);
    axi_read(5'h08, rd, resp);
    chk("t4_ien", rd, 32'h66);

    // 5: pin-change interrupt
    axi_write(5'h08, 32'h1, 4'hF, resp);
`ifdef GPIO_IRQ_EN
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, resp);
    repeat (2) @(negedge aclk);
    chk("t5_irq_cleared", 32'(irq), 32'h0);
    axi_read(5'h14, rd, resp);
    chk("t5_istat_cleared", rd, 32'h0);
    @(negedge aclk); gpio_in = 32'hA5A5_A5A4;
    begin
      int n;
      n = 0;
      while (!irq && n < 4) begin @(negedge aclk); n++; end
    end
    chk("t5_irq_set", 32'(irq), 32'h1);
    axi_read(5'h14, rd, resp);
    chk("t5_istat", rd, 32'h1);
    axi_write(5'h14, 32'h1, 4'hF, resp);
    chk("t5_irq_w1c", 32'(irq), 32'h0);
    axi_read(5'h14, rd, resp);
    chk("t5_istat_w1c", rd, 32'h0);
`else
    @(negedge aclk); gpio_in = 32'hA5A5_A5A4;
    repeat (5) @(negedge aclk);
    chk("t5_irq_tied", 32'(irq), 32'h0);
    axi_read(5'h14, rd, resp);
    chk("t5_istat_zero", rd, 32'h0);
    axi_read(5'h08, rd, resp);
    chk("t5_ien_rw", rd, 32'h1);
`endif

    // 6: reset while a read response is pending
    @(negedge aclk); gpio_in = 32'h0;
    @(negedge aclk);
    araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
    begin
      int n;
      n = 0;
      while (!arready && n < LIMIT) begin @(negedge aclk); n++; end
      if (n >= LIMIT) timeout_fail("t6_ar_wait");
      @(negedge aclk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < LIMIT) begin @(negedge aclk); n++; end
      if (n >= LIMIT) timeout_fail("t6_r_wait");
    end
    chk("t6_rdata_pending", rdata, 32'h55);
    aresetn = 1'b0;
    #1;
    chk("t6_rvalid_async", 32'(rvalid), 32'h0);
    chk("t6_rdata_async", rdata, 32'h0);
    chk("t6_gpio_out", gpio_out, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(4 * i), rd, resp);
      chk("t6_reg_zero", rd, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
